irq_pending_ctrl: RTL

Four-channel interrupt capture stage that feeds the team's 4-to-2 priority encoding path.
- Synchronises four asynchronous request lines.
- Latches each request event into a sticky pending bit.
- Offers the highest-priority pending channel as a 2-bit code over a valid/ready handshake, then clears that bit on acceptance.
- Sits between the raw request pins and the downstream interrupt servicing logic, so selection is done on registered, stable state rather than raw inputs.

---
 rtl/irq_pending_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - four-channel interrupt capture with sticky pending bits and a valid/ready grant
// Optional feature macro: IRQ_PENDING_CTRL_EDGE_DETECT_EN (defined: edge mode with lost flags; undefined: level mode)
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ready,
    input  logic       clr_lost,
    output logic       valid,
    output logic [1:0] code,
    output logic [3:0] pending,
    output logic [3:0] lost
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t     state;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] s_req;
    logic [3:0] set;
    logic [3:0] clr;
    logic       accept;
    logic [1:0] top_code;

    // Shift each request line through its synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= 4'b0000;
            end
        end else begin
            sync_q[0] <= req;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_req = sync_q[SYNC_STAGES-1];

`ifdef IRQ_PENDING_CTRL_EDGE_DETECT_EN
    logic [3:0] prev;

    // Remember last synchronised value so only rising edges count as events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 4'b0000;
        end else begin
            prev <= s_req;
        end
    end

    assign set = s_req & ~prev;

    // Flag events that land on a channel still pending; a new hit beats clr_lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost <= 4'b0000;
        end else begin
            lost <= (lost & {4{~clr_lost}}) | (set & pending & ~clr);
        end
    end
`else
    assign set  = s_req;
    assign lost = 4'b0000;
`endif

    // The offered channel is consumed when the handshake completes
    assign accept = valid & ready;
    assign clr    = accept ? (4'b0001 << code) : 4'b0000;

    // Sticky pending bits; a fresh event outranks the clear of the granted bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending & ~clr) | set;
        end
    end

    // Highest-index registered pending bit wins the next offer
    always_comb begin
        top_code = 2'd0;
        if (pending[3]) begin
            top_code = 2'd3;
        end else if (pending[2]) begin
            top_code = 2'd2;
        end else if (pending[1]) begin
            top_code = 2'd1;
        end
    end

    // Offer one code at a time and hold it until accepted; no preemption
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            code  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != 4'b0000) begin
                        code  <= top_code;
                        valid <= 1'b1;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
